modexpt_frame: RTL and testbench
================================

MODEXPT_FRAME -- requirements
Module: modexpt_frame

Interface
REQ-001 SHALL have parameter I_MSB, default 3: operand width DW = 2**(I_MSB+1) bits; base, modulus and result are DW bits; I_MSB >= 2 so DW is a multiple of 8.
REQ-002 SHALL have parameter J_MSB, default 3: exponent width EW = 2**(J_MSB+1) bits; J_MSB >= 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port enable, input, 1 bit: block enable; also drives me_enable combinationally.
REQ-006 SHALL have ports in_data input 8, in_valid input 1, in_ready output 1: the operand byte stream.
REQ-007 SHALL have ports out_data output 8, out_valid output 1, out_ready input 1: the result byte stream.
REQ-008 SHALL have ports me_req output 1 (toggle request) and me_ack input 1 (completion; rising edge = done) to the downstream exponentiator.
REQ-009 SHALL have ports me_base output DW, me_exp output EW, me_exp_msb output J_MSB+2, me_mod output DW, me_result input DW, me_enable output 1.
REQ-010 SHALL have ports busy output 1 (state != IDLE) and err output 1 (sticky zero-modulus flag).

Function
REQ-011 SHALL accept a frame of DW/8 base bytes, then EW/8 exponent bytes, then DW/8 modulus bytes, each operand LSB byte first; a byte is taken when in_valid & in_ready.
REQ-012 SHALL use states IDLE, LOAD_BASE, LOAD_EXP, LOAD_MOD, SCAN, ISSUE, WAIT, UNLOAD.
REQ-013 SHALL go IDLE->LOAD_BASE when enable=1; LOAD_* advance after the last byte of each operand, tracked by a byte counter that wraps to 0 at each operand boundary.
REQ-014 SHALL assert in_ready only in LOAD_BASE, LOAD_EXP and LOAD_MOD with enable=1.
REQ-015 SHALL, when the modulus is 0 at the end of LOAD_MOD, set err, issue no request and return to IDLE.
REQ-016 SHALL, in SCAN, test exponent bits from EW-1 downward, one bit per cycle, stopping at the first set bit; me_exp_msb = that index; exponent 0 gives index 0 after EW cycles.
REQ-017 SHALL hold me_base, me_exp, me_exp_msb and me_mod stable from ISSUE until leaving WAIT.
REQ-018 SHALL, in ISSUE, invert me_req once (one cycle) and enter WAIT.
REQ-019 SHALL detect a me_ack rising edge using a registered copy of me_ack, capture me_result on that edge and enter UNLOAD; ack edges outside WAIT SHALL be ignored.
REQ-020 SHALL, in UNLOAD, present DW/8 result bytes LSB first with out_valid=1, holding out_data while out_ready=0; after the last accepted byte, return to IDLE.
REQ-021 SHALL, if enable drops in LOAD_* or SCAN, discard the partial frame and go to IDLE next cycle; in ISSUE, WAIT and UNLOAD it SHALL ignore enable until the job completes.
REQ-022 SHALL allow back-to-back frames: IDLE->LOAD_BASE takes one cycle.
REQ-023 SHALL clear err only by reset.

Reset
REQ-024 SHALL, while rst=1, force state IDLE, counters 0, me_req 0, in_ready 0, out_valid 0, out_data 0, busy 0, err 0, ack-edge register 0, and all me_* operand registers 0.
REQ-025 SHALL, on reset mid-job, abandon the job; the bench re-resets the downstream block together with this block.

Structure
REQ-026 SHALL place the state enumeration and the DW, EW and DW/8 derived constants in a shared package rsa_pkg.
REQ-027 SHALL use one sub-module, byte_shift_reg, a parameterised byte-wide serial-in/serial-out shift register; it is instanced for operand assembly and for result unload.

Verification (DW=16, EW=16, behavioural exponentiator stub with a 20-cycle ack delay)
REQ-028 SHALL send bytes 03 00 11 00 07 00 -> SCAN takes 12 cycles, me_exp_msb=4, one me_req toggle, output bytes 05 00.
REQ-029 SHALL send an exponent of 0x0000 -> SCAN takes 16 cycles, me_exp_msb=0, request issued.
REQ-030 SHALL send a modulus of 0x0000 -> err=1, me_req unchanged, busy low after frame, next valid frame completes normally.
REQ-031 SHALL hold out_ready=0 for 5 cycles on the first result byte -> out_data stable, out_valid held, no byte lost.
REQ-032 SHALL drop enable after 3 input bytes -> IDLE, in_ready=0; a fresh full frame then yields the correct result.
REQ-033 SHALL assert rst during WAIT -> all outputs reach reset values immediately (asynchronously); a spurious ack afterwards produces no output.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared constants for the modular-exponentiation framer: FSM state codes
// and the operand/exponent width helpers.
package rsa_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD_BASE = 3'd1;
    localparam logic [2:0] S_LOAD_EXP  = 3'd2;
    localparam logic [2:0] S_LOAD_MOD  = 3'd3;
    localparam logic [2:0] S_SCAN      = 3'd4;
    localparam logic [2:0] S_ISSUE     = 3'd5;
    localparam logic [2:0] S_WAIT      = 3'd6;
    localparam logic [2:0] S_UNLOAD    = 3'd7;

    // Width in bits selected by an *_MSB parameter: 2**(msb+1).
    function automatic int width_of(input int msb);
        return 1 << (msb + 1);
    endfunction

    localparam int I_MSB_DEF = 3;
    localparam int J_MSB_DEF = 3;
    localparam int DW        = width_of(I_MSB_DEF);
    localparam int EW        = width_of(J_MSB_DEF);
    localparam int DW_BYTES  = DW / 8;

endpackage

// File: rtl/byte_shift_reg.sv
// Byte-wide shift register: bytes enter at the top and walk toward byte 0,
// so an LSB-first stream ends up in natural order; byte 0 is the serial out.
module byte_shift_reg #(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [8*NBYTES-1:0]   load_data,
    input  logic                  shift,
    input  logic [7:0]            din,
    output logic [8*NBYTES-1:0]   q,
    output logic [8*NBYTES-1:0]   q_shift
);
    localparam int W = 8 * NBYTES;

    logic [W-1:0] data_q, data_d;

    generate
        if (NBYTES == 1) begin : g_one
            assign q_shift = din;
        end else begin : g_multi
            assign q_shift = {din, data_q[W-1:8]};
        end
    endgenerate

    always_comb begin
        data_d = data_q;
        if (load)       data_d = load_data;
        else if (shift) data_d = q_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/modexpt_frame.sv
// Byte-stream framer around a toggle-handshake modular exponentiator:
// gathers base/exponent/modulus, finds the exponent MSB, issues, unloads.
module modexpt_frame
    import rsa_pkg::*;
#(
    parameter int I_MSB = 3,
    parameter int J_MSB = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [7:0]                     in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [7:0]                     out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           me_req,
    input  logic                           me_ack,
    output logic [width_of(I_MSB)-1:0]     me_base,
    output logic [width_of(J_MSB)-1:0]     me_exp,
    output logic [J_MSB+1:0]               me_exp_msb,
    output logic [width_of(I_MSB)-1:0]     me_mod,
    input  logic [width_of(I_MSB)-1:0]     me_result,
    output logic                           me_enable,
    output logic                           busy,
    output logic                           err
);
    localparam int OP_W = width_of(I_MSB);
    localparam int EX_W = width_of(J_MSB);
    localparam int OP_B = OP_W / 8;
    localparam int EX_B = EX_W / 8;
    localparam int AS_B = (OP_B > EX_B) ? OP_B : EX_B;
    localparam int AS_W = 8 * AS_B;
    localparam int CW   = $clog2(AS_B) + 1;
    localparam logic [CW-1:0] OP_LAST = CW'(OP_B - 1);
    localparam logic [CW-1:0] EX_LAST = CW'(EX_B - 1);

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [J_MSB:0]  bit_q, bit_d;
    logic            req_q, req_d;
    logic            err_q, err_d;
    logic            ack_q;
    logic [OP_W-1:0] base_q, base_d, mod_q, mod_d;
    logic [EX_W-1:0] exp_q, exp_d;
    logic [J_MSB+1:0] msb_q, msb_d;

    logic            take, ack_rise, out_take;
    logic [AS_W-1:0] asm_q, asm_nxt;
    logic [OP_W-1:0] unl_q, unl_nxt;
    logic [OP_W-1:0] op_slice;
    logic [EX_W-1:0] ex_slice;
    logic            unused_bits;

    assign take     = in_valid & in_ready;
    assign ack_rise = me_ack & ~ack_q;
    assign out_take = out_valid & out_ready;

    // The assembler is as wide as the widest operand; the newest bytes sit at
    // the top, so each operand is the top slice of the post-shift value.
    assign op_slice = asm_nxt[AS_W-1 -: OP_W];
    assign ex_slice = asm_nxt[AS_W-1 -: EX_W];

    byte_shift_reg #(.NBYTES(AS_B)) u_asm (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ('0),
        .shift     (take),
        .din       (in_data),
        .q         (asm_q),
        .q_shift   (asm_nxt)
    );

    byte_shift_reg #(.NBYTES(OP_B)) u_unl (
        .clk       (clk),
        .rst       (rst),
        .load      ((state_q == S_WAIT) && ack_rise),
        .load_data (me_result),
        .shift     (out_take),
        .din       (8'h00),
        .q         (unl_q),
        .q_shift   (unl_nxt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        req_d   = req_q;
        err_d   = err_q;
        base_d  = base_q;
        exp_d   = exp_q;
        mod_d   = mod_q;
        msb_d   = msb_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (enable) state_d = S_LOAD_BASE;
            end
            S_LOAD_BASE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (take) begin
                    if (cnt_q == OP_LAST) begin
                        base_d  = op_slice;
                        cnt_d   = '0;
                        state_d = S_LOAD_EXP;
                    end else cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOAD_EXP: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (take) begin
                    if (cnt_q == EX_LAST) begin
                        exp_d   = ex_slice;
                        cnt_d   = '0;
                        state_d = S_LOAD_MOD;
                    end else cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOAD_MOD: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (take) begin
                    if (cnt_q == OP_LAST) begin
                        mod_d = op_slice;
                        cnt_d = '0;
                        bit_d = {(J_MSB+1){1'b1}};
                        // A zero modulus has no defined result: flag it and drop the job.
                        if (op_slice == '0) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else state_d = S_SCAN;
                    end else cnt_d = cnt_q + 1'b1;
                end
            end
            S_SCAN: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (exp_q[bit_q] || (bit_q == '0)) begin
                    msb_d   = {1'b0, bit_q};
                    state_d = S_ISSUE;
                end else bit_d = bit_q - 1'b1;
            end
            S_ISSUE: begin
                req_d   = ~req_q;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ack_rise) begin
                    cnt_d   = '0;
                    state_d = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                if (out_ready) begin
                    if (cnt_q == OP_LAST) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            base_q  <= '0;
            exp_q   <= '0;
            mod_q   <= '0;
            msb_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            req_q   <= req_d;
            err_q   <= err_d;
            ack_q   <= me_ack;
            base_q  <= base_d;
            exp_q   <= exp_d;
            mod_q   <= mod_d;
            msb_q   <= msb_d;
        end
    end

    assign in_ready   = enable && ((state_q == S_LOAD_BASE) || (state_q == S_LOAD_EXP) ||
                                   (state_q == S_LOAD_MOD));
    assign out_valid  = (state_q == S_UNLOAD);
    assign out_data   = out_valid ? unl_q[7:0] : 8'h00;
    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;
    assign me_req     = req_q;
    assign me_enable  = enable;
    assign me_base    = base_q;
    assign me_exp     = exp_q;
    assign me_mod     = mod_q;
    assign me_exp_msb = msb_q;

    assign unused_bits = ^{asm_q, unl_q, unl_nxt};

endmodule

// File: tb/tb_modexpt_frame.sv
// Randomised bench for modexpt_frame with a behavioural exponentiator stub
// (20-cycle ack delay) and a reference model of the frame/scan/result rules.
module tb_modexpt_frame;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        me_req, me_ack, me_enable, busy, err;
    logic [15:0] me_base, me_exp, me_mod, me_result;
    logic [4:0]  me_exp_msb;

    modexpt_frame #(.I_MSB(3), .J_MSB(3)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .me_req(me_req), .me_ack(me_ack), .me_base(me_base), .me_exp(me_exp),
        .me_exp_msb(me_exp_msb), .me_mod(me_mod), .me_result(me_result),
        .me_enable(me_enable), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    function automatic longint unsigned modexp(input logic [15:0] b, input logic [15:0] e,
                                               input logic [15:0] m);
        longint unsigned r, x;
        if (m == 16'd0) return 0;
        r = 1 % longint'(m);
        x = b % m;
        for (int i = 0; i < 16; i++) begin
            if (e[i]) r = (r * x) % m;
            x = (x * x) % m;
        end
        return r;
    endfunction

    function automatic int msb_of(input logic [15:0] e);
        for (int i = 15; i >= 0; i--) if (e[i]) return i;
        return 0;
    endfunction

    // Downstream exponentiator stub: one-cycle ack pulse 20 cycles after a toggle.
    logic        stub_ack, spur_ack = 1'b0, req_seen;
    int          dly;
    logic [15:0] res;
    assign me_ack    = stub_ack | spur_ack;
    assign me_result = res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_ack <= 1'b0;
            req_seen <= 1'b0;
            dly      <= 0;
            res      <= 16'h0;
        end else if (me_req != req_seen) begin
            req_seen <= me_req;
            dly      <= 20;
            res      <= 16'(modexp(me_base, me_exp, me_mod));
        end else if (dly > 0) begin
            dly <= dly - 1;
            if (dly == 1) stub_ack <= 1'b1;
        end else stub_ack <= 1'b0;
    end

    // Reference model state
    logic [15:0] m_base, m_exp, m_mod;
    bit          expect_req = 0;
    logic [7:0]  expq[$];
    logic [7:0]  got_q[$];
    int          req_cnt = 0, last_hs = 0, last_scan = 0, last_msb = 0, cyc = 0;
    logic        req_prev = 1'b0;
    bit          hold_rdy = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (!hold_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Compare process
    initial forever begin
        longint unsigned r;
        @(negedge clk);
        if (rst) begin
            req_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) last_hs = cyc;
            if (me_req !== req_prev) begin
                req_prev = me_req;
                req_cnt++;
                chk("req_expected", expect_req, 1);
                chk("me_base", me_base, m_base);
                chk("me_exp", me_exp, m_exp);
                chk("me_mod", me_mod, m_mod);
                chk("me_exp_msb", me_exp_msb, msb_of(m_exp));
                last_msb  = me_exp_msb;
                last_scan = cyc - last_hs - 2;
                chk("scan_cycles", last_scan, (m_exp == 16'd0) ? 16 : 16 - msb_of(m_exp));
                r = modexp(m_base, m_exp, m_mod);
                expq.push_back(r[7:0]);
                expq.push_back(r[15:8]);
                expect_req = 0;
            end
            if (out_valid) begin
                if (expq.size() == 0) chk("out_unexpected", 1, 0);
                else begin
                    chk("out_data", out_data, expq[0]);
                    if (out_ready) begin
                        got_q.push_back(out_data);
                        void'(expq.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        repeat ($urandom_range(0, 1)) @(posedge clk);
        #1;
        in_data  = b;
        in_valid = 1'b1;
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic send_frame(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m);
        m_base = b;
        m_exp  = e;
        m_mod  = m;
        expect_req = (m != 16'd0);
        send_byte(b[7:0]); send_byte(b[15:8]);
        send_byte(e[7:0]); send_byte(e[15:8]);
        send_byte(m[7:0]); send_byte(m[15:8]);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (!expect_req && expq.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("frame_done_timeout", 0, 1);
    endtask

    initial begin
        int rc;
        bit seen;
        logic [7:0] d;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_me_req", me_req, 0);
        chk("rst_me_base", me_base, 0);
        chk("rst_me_exp", me_exp, 0);
        chk("rst_me_mod", me_mod, 0);
        chk("rst_me_msb", me_exp_msb, 0);
        chk("model_pin", modexp(16'd3, 16'h11, 16'd7), 5);
        rst = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        chk("me_enable", me_enable, 1);

        // Directed: 3^17 mod 7 = 5
        got_q.delete();
        send_frame(16'h0003, 16'h0011, 16'h0007);
        wait_done();
        chk("d1_req_cnt", req_cnt, 1);
        chk("d1_scan", last_scan, 12);
        chk("d1_msb", last_msb, 4);
        chk("d1_nbytes", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("d1_byte0", got_q[0], 8'h05);
            chk("d1_byte1", got_q[1], 8'h00);
        end

        // Zero exponent: full 16-cycle scan, MSB index 0
        send_frame(16'(($urandom)), 16'h0000, 16'($urandom_range(2, 65535)));
        wait_done();
        chk("z_scan", last_scan, 16);
        chk("z_msb", last_msb, 0);

        // Zero modulus: err, no request, back to IDLE
        rc = req_cnt;
        send_frame(16'h1234, 16'h0005, 16'h0000);
        chk("zm_busy_low", busy, 0);
        chk("zm_err", err, 1);
        repeat (30) @(posedge clk);
        chk("zm_no_req", req_cnt, rc);
        send_frame(16'(($urandom)), 16'(($urandom)), 16'($urandom_range(1, 65535)));
        wait_done();
        chk("zm_recover_req", req_cnt, rc + 1);
        chk("err_sticky", err, 1);

        // Output back-pressure on the first result byte
        @(posedge clk);
        #1;
        hold_rdy = 1;
        out_ready = 1'b0;
        got_q.delete();
        send_frame(16'(($urandom)), 16'(($urandom)), 16'($urandom_range(1, 65535)));
        seen = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        chk("stall_out_valid_seen", seen, 1);
        d = out_data;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, d);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        hold_rdy = 0;
        wait_done();
        chk("stall_nbytes", got_q.size(), 2);

        // Enable drop after three input bytes
        m_base = 16'hBEEF; m_exp = 16'h0101; expect_req = 0;
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'h01);
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(negedge clk);
        chk("drop_in_ready", in_ready, 0);
        @(negedge clk);
        chk("drop_busy", busy, 0);
        chk("drop_in_ready2", in_ready, 0);
        @(posedge clk);
        #1;
        enable = 1'b1;
        send_frame(16'h0a0b, 16'h0203, 16'h7fff);
        wait_done();

        // Randomised frames
        for (int k = 0; k < 25; k++) begin
            logic [15:0] e;
            e = 16'($urandom) >> $urandom_range(0, 15);
            send_frame(16'(($urandom)), e, 16'($urandom_range(1, 65535)));
            wait_done();
        end

        // Reset while waiting for the exponentiator
        send_frame(16'h1111, 16'h2222, 16'h3333);
        for (int n = 0; n < 200 && expect_req; n++) @(negedge clk);
        chk("wait_req_issued", expect_req, 0);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_me_req", me_req, 0);
        chk("ar_out_valid", out_valid, 0);
        chk("ar_out_data", out_data, 0);
        chk("ar_in_ready", in_ready, 0);
        chk("ar_err", err, 0);
        chk("ar_me_base", me_base, 0);
        chk("ar_me_exp", me_exp, 0);
        chk("ar_me_mod", me_mod, 0);
        chk("ar_me_msb", me_exp_msb, 0);
        expq.delete();
        expect_req = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        spur_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        spur_ack = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("spurious_ack_out", seen, 0);

        send_frame(16'hCAFE, 16'h0013, 16'hFFF1);
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
